// File: rtl/dw_seq_pkg.sv
// Shared types and constants for the depthwise cluster sequencer.
package dw_seq_pkg;
    localparam int LANES          = 4;
    localparam int MAX_TAPS_DEF   = 25;
    localparam int PE_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_OUT
    } state_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input int n);
        return w[8*n +: 8];
    endfunction
endpackage

// File: rtl/dw_seq_tap_driver.sv
// Registered cluster-side tap mux: presents an accepted tap one cycle later,
// otherwise drives zeros so the PEs see a zero product.
module dw_seq_tap_driver
    import dw_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic        last_tap,
    input  logic [31:0] ifm_data,
    input  logic [31:0] wgt_data,
    output logic [31:0] pe_ifm,
    output logic [7:0]  pe_weight_0,
    output logic [7:0]  pe_weight_1,
    output logic [7:0]  pe_weight_2,
    output logic [7:0]  pe_weight_3,
    output logic        pe_reset,
    output logic        pe_finish
);
    logic [31:0]            ifm_d, ifm_q;
    logic [LANES-1:0][7:0]  wgt_d, wgt_q;
    logic                   reset_d, reset_q;
    logic                   finish_d, finish_q;

    always_comb begin
        ifm_d    = '0;
        wgt_d    = '0;
        finish_d = 1'b0;
        reset_d  = clear;
        if (accept) begin
            ifm_d    = ifm_data;
            finish_d = last_tap;
            for (int n = 0; n < LANES; n++) begin
                wgt_d[n] = lane_byte(wgt_data, n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            ifm_q    <= '0;
            wgt_q    <= '0;
            reset_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            ifm_q    <= ifm_d;
            wgt_q    <= wgt_d;
            reset_q  <= reset_d;
            finish_q <= finish_d;
        end
    end

    assign pe_ifm      = ifm_q;
    assign pe_weight_0 = wgt_q[0];
    assign pe_weight_1 = wgt_q[1];
    assign pe_weight_2 = wgt_q[2];
    assign pe_weight_3 = wgt_q[3];
    assign pe_reset    = reset_q;
    assign pe_finish   = finish_q;
endmodule

// File: rtl/dw_cluster_sequencer.sv
// Window sequencer for a 4-lane depthwise PE cluster: clears, feeds K*K taps,
// waits out the PE latency and hands the captured OFM word downstream.
module dw_cluster_sequencer
    import dw_seq_pkg::*;
#(
    parameter int MAX_TAPS   = MAX_TAPS_DEF,
    parameter int TAP_W      = 5,
    parameter int WIN_W      = 16,
    parameter int PE_LATENCY = PE_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [TAP_W-1:0] num_taps,
    input  logic [WIN_W-1:0] num_windows,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      ifm_data,
    input  logic             ifm_valid,
    output logic             ifm_ready,
    input  logic [31:0]      wgt_data,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    output logic [31:0]      pe_ifm,
    output logic [7:0]       pe_weight_0,
    output logic [7:0]       pe_weight_1,
    output logic [7:0]       pe_weight_2,
    output logic [7:0]       pe_weight_3,
    output logic             pe_reset,
    output logic             pe_finish,
    input  logic [7:0]       pe_ofm_0,
    input  logic [7:0]       pe_ofm_1,
    input  logic [7:0]       pe_ofm_2,
    input  logic [7:0]       pe_ofm_3,
    output logic [31:0]      ofm_data,
    output logic             ofm_valid,
    input  logic             ofm_ready
);
    localparam int DCW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic [TAP_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [31:0]      ofm_data_q, ofm_data_d;
    logic             ofm_valid_q, ofm_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept, last_tap, bad_job;

    assign accept   = (state_q == ST_FEED) && ifm_valid && wgt_valid;
    assign last_tap = (tap_cnt_q == taps_q - TAP_W'(1));
    assign bad_job  = (num_taps == '0) || (num_windows == '0) ||
                      ({1'b0, num_taps} > (TAP_W+1)'(MAX_TAPS));

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        tap_cnt_d   = tap_cnt_q;
        win_d       = win_q;
        drain_d     = drain_q;
        ofm_data_d  = ofm_data_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    taps_d = num_taps;
                    win_d  = num_windows;
                    if (bad_job) done_d  = 1'b1;
                    else         state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                tap_cnt_d = '0;
                state_d   = ST_FEED;
            end
            ST_FEED: begin
                if (accept) begin
                    tap_cnt_d = tap_cnt_q + TAP_W'(1);
                    if (last_tap) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Lanes are sampled on the last cycle before the OFM becomes visible downstream.
                if (drain_q == DCW'(PE_LATENCY - 1)) begin
                    ofm_data_d = {pe_ofm_3, pe_ofm_2, pe_ofm_1, pe_ofm_0};
                    state_d    = ST_OUT;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            ST_OUT: begin
                if (ofm_ready) begin
                    win_d = win_q - WIN_W'(1);
                    if (win_q == WIN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ofm_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= ST_IDLE;
            taps_q      <= '0;
            tap_cnt_q   <= '0;
            win_q       <= '0;
            drain_q     <= '0;
            ofm_data_q  <= '0;
            ofm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            tap_cnt_q   <= tap_cnt_d;
            win_q       <= win_d;
            drain_q     <= drain_d;
            ofm_data_q  <= ofm_data_d;
            ofm_valid_q <= ofm_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    dw_seq_tap_driver u_tap (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (state_d == ST_CLEAR),
        .accept      (accept),
        .last_tap    (last_tap),
        .ifm_data    (ifm_data),
        .wgt_data    (wgt_data),
        .pe_ifm      (pe_ifm),
        .pe_weight_0 (pe_weight_0),
        .pe_weight_1 (pe_weight_1),
        .pe_weight_2 (pe_weight_2),
        .pe_weight_3 (pe_weight_3),
        .pe_reset    (pe_reset),
        .pe_finish   (pe_finish)
    );

    assign ifm_ready = (state_q == ST_FEED) && wgt_valid;
    assign wgt_ready = (state_q == ST_FEED) && ifm_valid;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ofm_data  = ofm_data_q;
    assign ofm_valid = ofm_valid_q;
endmodule

// File: tb/tb_dw_cluster_sequencer.sv
// Directed bench for the depthwise cluster sequencer with a behavioural PE cluster
// and a per-window OFM model computed from the tap tables.
module tb_dw_cluster_sequencer;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  num_taps = '0;
    logic [15:0] num_windows = '0;
    logic        busy, done;
    logic [31:0] ifm_data = '0, wgt_data = '0;
    logic        ifm_valid = 1'b0, wgt_valid = 1'b0;
    logic        ifm_ready, wgt_ready;
    logic [31:0] pe_ifm;
    logic [7:0]  pe_weight_0, pe_weight_1, pe_weight_2, pe_weight_3;
    logic        pe_reset, pe_finish;
    logic [7:0]  pe_ofm_0, pe_ofm_1, pe_ofm_2, pe_ofm_3;
    logic [31:0] ofm_data;
    logic        ofm_valid;
    logic        ofm_ready = 1'b1;

    always #5 clk = ~clk;

    dw_cluster_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_taps(num_taps),
        .num_windows(num_windows), .busy(busy), .done(done),
        .ifm_data(ifm_data), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .pe_ifm(pe_ifm), .pe_weight_0(pe_weight_0), .pe_weight_1(pe_weight_1),
        .pe_weight_2(pe_weight_2), .pe_weight_3(pe_weight_3),
        .pe_reset(pe_reset), .pe_finish(pe_finish),
        .pe_ofm_0(pe_ofm_0), .pe_ofm_1(pe_ofm_1), .pe_ofm_2(pe_ofm_2), .pe_ofm_3(pe_ofm_3),
        .ofm_data(ofm_data), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready)
    );

    int nvec = 0, nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural cluster: lanes accumulate byte products; OFM is only meaningful
    // once PL-1 cycles have passed since pe_finish, garbage (0xEE) before that.
    logic [7:0] acc [4] = '{default: 8'h00};
    logic [7:0] pe_w [4];
    int fin_age = 0;
    assign pe_w[0] = pe_weight_0;
    assign pe_w[1] = pe_weight_1;
    assign pe_w[2] = pe_weight_2;
    assign pe_w[3] = pe_weight_3;
    always @(posedge clk) begin
        if (pe_reset) begin
            for (int n = 0; n < 4; n++) acc[n] <= 8'h00;
            fin_age <= 0;
        end else begin
            for (int n = 0; n < 4; n++) acc[n] <= acc[n] + 8'(pe_ifm[8*n +: 8] * pe_w[n]);
            if (pe_finish) fin_age <= 1;
            else if (fin_age != 0 && fin_age < 1000) fin_age <= fin_age + 1;
        end
    end
    logic ofm_ok;
    assign ofm_ok   = (fin_age != 0) && (fin_age >= PL - 1);
    assign pe_ofm_0 = ofm_ok ? acc[0] : 8'hEE;
    assign pe_ofm_1 = ofm_ok ? acc[1] : 8'hEE;
    assign pe_ofm_2 = ofm_ok ? acc[2] : 8'hEE;
    assign pe_ofm_3 = ofm_ok ? acc[3] : 8'hEE;

    logic [31:0] ifm_tab [25];
    logic [31:0] wgt_tab [25];
    logic [31:0] exp_q [$];
    int reset_q[$], fin_q[$], tap_q[$], done_q[$], rise_q[$], hs_q[$];
    int ready_cnt = 0, busy_cnt = 0;
    logic [31:0] last_ofm = '0;
    logic vprev = 1'b0;
    int t_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ifm_of(input int t, input int w);
        return ifm_tab[t] + 32'h01010101 * 32'(w);
    endfunction

    // Expected OFM word: per lane, sum of IFM byte * weight byte over the window, mod 256.
    function automatic logic [31:0] model_word(input int nt, input int w);
        logic [7:0] s [4];
        logic [31:0] a, b;
        for (int n = 0; n < 4; n++) s[n] = 8'h00;
        for (int t = 0; t < nt; t++) begin
            a = ifm_of(t, w);
            b = wgt_tab[t];
            for (int n = 0; n < 4; n++) s[n] = s[n] + 8'(a[8*n +: 8] * b[8*n +: 8]);
        end
        return {s[3], s[2], s[1], s[0]};
    endfunction

    always @(negedge clk) begin
        if (pe_reset)  reset_q.push_back(cyc);
        if (pe_finish) fin_q.push_back(cyc);
        if (pe_ifm != 0) tap_q.push_back(cyc);
        if (done)      done_q.push_back(cyc);
        if (ifm_ready || wgt_ready) ready_cnt <= ready_cnt + 1;
        if (busy)      busy_cnt <= busy_cnt + 1;
        if (pe_reset && pe_finish) chk("reset_finish_overlap", 32'd1, 32'd0);
        if (ofm_valid && !vprev) rise_q.push_back(cyc);
        if (ofm_valid) begin
            if (exp_q.size() == 0) chk("ofm_unexpected_valid", 32'd1, 32'd0);
            else begin
                chk("ofm_data", ofm_data, exp_q[0]);
                if (ofm_ready) begin
                    hs_q.push_back(cyc);
                    last_ofm <= ofm_data;
                    void'(exp_q.pop_front());
                end
            end
        end
        vprev <= ofm_valid;
    end

    task automatic clear_logs();
        reset_q.delete(); fin_q.delete(); tap_q.delete();
        done_q.delete(); rise_q.delete(); hs_q.delete();
        ready_cnt = 0; busy_cnt = 0;
    endtask

    task automatic run_job(input int nt, input int nw, input bit gap, input int stall_win, input int stall_n);
        for (int w = 0; w < nw; w++) exp_q.push_back(model_word(nt, w));
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_taps = 5'(nt); num_windows = 16'(nw); t_start = cyc;
        fork
            begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            begin : feeder
                int w = 0, t = 0, budget = 3000;
                bit ph = 1'b1, hs;
                while (w < nw && budget > 0) begin
                    ifm_valid = 1'b1;
                    wgt_valid = gap ? ph : 1'b1;
                    ifm_data  = ifm_of(t, w);
                    wgt_data  = wgt_tab[t];
                    @(negedge clk);
                    hs = ifm_valid && wgt_valid && ifm_ready && wgt_ready;
                    @(posedge clk); #1;
                    ph = ~ph; budget--;
                    if (hs) begin
                        t++;
                        if (t == nt) begin t = 0; w++; end
                    end
                end
                ifm_valid = 1'b0; wgt_valid = 1'b0;
                if (budget == 0) chk("feeder_timeout", 32'(w), 32'(nw));
            end
            begin : consumer
                int left = stall_n, b = 0;
                while (hs_q.size() < nw && b < 3000) begin
                    if (hs_q.size() == stall_win && left > 0) begin
                        ofm_ready = 1'b0;
                        if (ofm_valid) left--;
                    end else ofm_ready = 1'b1;
                    @(posedge clk); #1;
                    b++;
                end
                ofm_ready = 1'b1;
                if (b == 3000) chk("consumer_timeout", 32'(hs_q.size()), 32'(nw));
            end
        join
        for (int i = 0; i < 40 && done_q.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("job_done_count", 32'(done_q.size()), 32'd1);
        chk("job_ofm_words", 32'(hs_q.size()), 32'(nw));
        chk("job_clear_count", 32'(reset_q.size()), 32'(nw));
        chk("job_finish_count", 32'(fin_q.size()), 32'(nw));
        if (done_q.size() > 0 && hs_q.size() > 0)
            chk("done_after_handshake", 32'(done_q[0]), 32'(hs_q[hs_q.size()-1] + 1));
    endtask

    task automatic run_bad(input int nt, input int nw);
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_taps = 5'(nt); num_windows = 16'(nw); t_start = cyc;
        ifm_valid = 1'b1; wgt_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ifm_valid = 1'b0; wgt_valid = 1'b0;
        chk("bad_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("bad_done_cycle", 32'(done_q[0]), 32'(t_start + 1));
        chk("bad_no_clear", 32'(reset_q.size()), 32'd0);
        chk("bad_no_ready", 32'(ready_cnt), 32'd0);
        chk("bad_no_ofm", 32'(rise_q.size()), 32'd0);
        chk("bad_not_busy", 32'(busy_cnt), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ready"}, {30'd0, ifm_ready, wgt_ready}, 32'd0);
        chk({tag, "_pe_ifm"}, pe_ifm, 32'd0);
        chk({tag, "_pe_wgt"}, {pe_weight_3, pe_weight_2, pe_weight_1, pe_weight_0}, 32'd0);
        chk({tag, "_pe_ctl"}, {30'd0, pe_reset, pe_finish}, 32'd0);
        chk({tag, "_ofm_valid"}, 32'(ofm_valid), 32'd0);
        chk({tag, "_ofm_data"}, ofm_data, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Job 1: 9 taps, IFM bytes 1..9, weights 1 -> each lane 45.
        for (int t = 0; t < 25; t++) begin
            ifm_tab[t] = 32'h01010101 * 32'(t + 1);
            wgt_tab[t] = 32'h01010101;
        end
        run_job(9, 1, 1'b0, -1, 0);
        chk("t1_pe_reset_cycle", 32'(reset_q.size() > 0 ? reset_q[0] : -1), 32'(t_start + 1));
        chk("t1_tap_count", 32'(tap_q.size()), 32'd9);
        if (tap_q.size() == 9) begin
            chk("t1_first_tap", 32'(tap_q[0]), 32'(t_start + 3));
            chk("t1_last_tap", 32'(tap_q[8]), 32'(t_start + 11));
        end
        chk("t1_finish_cycle", 32'(fin_q.size() > 0 ? fin_q[0] : -1), 32'(t_start + 11));
        chk("t1_ofm_valid_cycle", 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'(t_start + 13));
        chk("t1_ofm_literal", last_ofm, 32'h2D2D2D2D);

        // Job 2: same taps, weight stream valid every other cycle.
        run_job(9, 1, 1'b1, -1, 0);
        chk("t2_tap_count", 32'(tap_q.size()), 32'd9);
        if (tap_q.size() == 9) begin
            chk("t2_tap_span", 32'(tap_q[8] - tap_q[0]), 32'd16);
            chk("t2_finish_on_last", 32'(fin_q.size() > 0 ? fin_q[0] : -1), 32'(tap_q[8]));
        end
        chk("t2_ofm_literal", last_ofm, 32'h2D2D2D2D);

        // Job 3: 3 windows x 4 taps, 5-cycle backpressure on window 2.
        for (int t = 0; t < 4; t++) begin
            ifm_tab[t] = 32'h01020304 * 32'(t + 1);
            wgt_tab[t] = 32'h05060708 + 32'(t);
        end
        run_job(4, 3, 1'b0, 1, 5);
        if (hs_q.size() == 3 && rise_q.size() == 3 && reset_q.size() == 3) begin
            chk("t3_stall_len", 32'(hs_q[1] - rise_q[1]), 32'd5);
            chk("t3_clear2_after_hs", 32'(reset_q[1]), 32'(hs_q[0] + 1));
            chk("t3_clear3_after_hs", 32'(reset_q[2]), 32'(hs_q[1] + 1));
        end else chk("t3_event_counts", 32'(hs_q.size()), 32'd3);

        // Job 4: single-tap lane mapping.
        ifm_tab[0] = 32'h04030201;
        wgt_tab[0] = 32'h01020304;
        run_job(1, 1, 1'b0, -1, 0);
        chk("t4_lane_literal", last_ofm, 32'h04060604);
        chk("t4_reset_cycle", 32'(reset_q.size() > 0 ? reset_q[0] : -1), 32'(t_start + 1));
        chk("t4_finish_cycle", 32'(fin_q.size() > 0 ? fin_q[0] : -1), 32'(t_start + 3));

        // Illegal jobs complete immediately.
        run_bad(0, 1);
        run_bad(26, 1);
        run_bad(9, 0);

        // Reset during FEED, on the 5th presented tap of 9.
        for (int t = 0; t < 25; t++) begin
            ifm_tab[t] = 32'h01010101 * 32'(t + 1);
            wgt_tab[t] = 32'h01010101;
        end
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_taps = 5'd9; num_windows = 16'd1; t_start = cyc;
        ifm_valid = 1'b1; wgt_valid = 1'b1; ifm_data = 32'h05050505; wgt_data = 32'h01010101;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && cyc < t_start + 7; i++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        chk("rst_taps_before_abort", 32'(tap_q.size()), 32'd5);
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk); #1;
        ifm_valid = 1'b0; wgt_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_q.size()), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        run_job(9, 1, 1'b0, -1, 0);
        chk("post_abort_ofm", last_ofm, 32'h2D2D2D2D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
